hmem_arbiter: RTL and testbench
===============================

Name: hmem_arbiter

Overview:
- Two-requester arbiter downstream of the instruction and data caches.
- Merges their higher-memory traffic (line fills and dirty-line writebacks, one word per beat) onto the single main-memory port.
- Round-robin between requesters. Grant stays locked for a whole multi-beat line transfer, so fill and writeback bursts are never interleaved.
- Requests are registered before going to memory, and responses are returned to the owning requester only.

Parameters:
- XLEN, 32, address and data width in bits.
- NUM_REQ, 2, number of requesters (fixed at 2; index 0 = icache, index 1 = dcache).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_if  input  reset_if  reset is asynchronous and active-low: asserting low clears all state immediately, independent of clk.
- req_valid  input  [NUM_REQ]  requester r holds a beat request.
- req_lock  input  [NUM_REQ]  requester r keeps ownership after the current beat.
- req_write  input  [NUM_REQ]  1 = write beat, 0 = read beat.
- req_addr  input  [NUM_REQ][XLEN]  word address of the beat.
- req_wdata  input  [NUM_REQ][XLEN]  write data.
- req_fulfilled  output  [NUM_REQ]  one-cycle done pulse to requester r.
- req_rdata  output  XLEN  read data; valid while any req_fulfilled bit is high.
- mem_valid  output  1  beat presented to memory.
- mem_write  output  1  registered op.
- mem_addr  output  XLEN  registered address.
- mem_wdata  output  XLEN  registered write data.
- mem_rdata  input  XLEN  read data from memory.
- mem_fulfilled  input  1  memory completes the current beat (single-cycle pulse).

Behaviour:
- States: IDLE, ISSUE, RESPOND. Registers: owner (1b), last_owner (1b), and the registered mem_* fields.
- Reset values: state=IDLE, owner=0, last_owner=1 (so requester 0 wins the first tie), mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, req_fulfilled=0, req_rdata=0.
- IDLE:
  - No req_valid bit set: stay in IDLE.
  - Exactly one bit set: that requester becomes owner.
  - Both set: owner = ~last_owner.
  - On exiting IDLE, latch the owner's write/addr/wdata into mem_* and go to ISSUE.
  - Latency is 1 cycle from req_valid to mem_valid.
- ISSUE:
  - mem_valid=1; mem_* held stable.
  - Wait any number of cycles for mem_fulfilled.
  - On mem_fulfilled: capture mem_rdata into req_rdata (read beats only; write beats leave it unchanged), drop mem_valid, go to RESPOND.
- RESPOND:
  - req_fulfilled[owner]=1 for exactly this cycle; the other bit stays 0.
  - Requester must deassert req_valid or present its next beat in the following cycle. Requester inputs are sampled in RESPOND itself.
  - req_lock[owner]=1 and req_valid[owner]=1: latch the new beat and go straight to ISSUE. Owner is kept and the other requester is ignored.
  - Otherwise: last_owner=owner, go to IDLE. Re-arbitration takes one cycle.
- Lock is sampled only in RESPOND. Changing lock during ISSUE has no effect on the current beat.
- A requester that drops req_valid while in ISSUE does not cancel the beat. The beat completes and the fulfilled pulse is still issued; the requester discards it.
- A non-owner's req_valid is held off indefinitely while the owner keeps lock. There is no timeout.
- mem_fulfilled seen in IDLE or RESPOND is ignored (protocol error; no state change).
- Reset mid-ISSUE aborts the beat: mem_valid falls immediately and arbitration restarts from the reset values.

Optional Feature:
- Macro HMEM_ARB_STATS_EN.
- Defined: adds outputs stat_grants [NUM_REQ][32] and stat_wait_cycles [NUM_REQ][32].
  - stat_grants[r] increments on each IDLE->ISSUE transition that grants r.
  - stat_wait_cycles[r] increments on every cycle where req_valid[r]=1 and r is not the current owner in ISSUE/RESPOND.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single read: req_valid=2'b10, addr=0x100, memory acks 3 cycles after mem_valid with rdata=0xDEADBEEF -> mem_valid rises 1 cycle after req_valid with mem_addr=0x100, mem_write=0; req_fulfilled=2'b10 for one cycle; req_rdata=0xDEADBEEF.
- Tie from reset: both requesters valid (addr0=0x40, addr1=0x80), memory acks after 1 cycle -> first mem_addr=0x40. After release, second grant goes to requester 1 (mem_addr=0x80).
- Locked 8-beat line fill by dcache with icache valid throughout -> 8 consecutive mem beats with addresses 0x200..0x21C, all owned by requester 1. Icache is granted only after the beat in which lock=0.
- Writeback then fill: dcache write of 0x12345678 to 0x300 with lock=0, then a read -> mem_write=1 with mem_wdata=0x12345678; req_rdata unchanged by the write beat.
- Reset asserted low while in ISSUE -> mem_valid=0 and req_fulfilled=0 immediately, without waiting for a clock edge. After release, a new request is accepted normally.
- With HMEM_ARB_STATS_EN: icache waits 5 cycles behind a dcache burst -> stat_wait_cycles[0]=5, stat_grants[1]=1.

Source files
------------

// File: rtl/hmem_arbiter_if.sv
// rtl/hmem_arbiter_if.sv - reset interface carrying the asynchronous active-low reset
interface reset_if;
    logic rst_n;

    modport sink   (input  rst_n);
    modport source (output rst_n);
endinterface

// File: rtl/hmem_arbiter.sv
// rtl/hmem_arbiter.sv - two-requester round-robin arbiter onto the main-memory port (optional stats: HMEM_ARB_STATS_EN)
module hmem_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                           clk_i,
    reset_if.sink                          rst_if,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_lock_i,
    input  logic [NUM_REQ-1:0]             req_write_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]             req_fulfilled_o,
    output logic [XLEN-1:0]                req_rdata_o,
    output logic                           mem_valid_o,
    output logic                           mem_write_o,
    output logic [XLEN-1:0]                mem_addr_o,
    output logic [XLEN-1:0]                mem_wdata_o,
    input  logic [XLEN-1:0]                mem_rdata_i,
    input  logic                           mem_fulfilled_i
`ifdef HMEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]       stat_grants_o,
    output logic [NUM_REQ-1:0][31:0]       stat_wait_cycles_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 mem_write_q, mem_write_d;
    logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
    logic [NUM_REQ-1:0]   req_fulfilled_q, req_fulfilled_d;
    logic [XLEN-1:0]      req_rdata_q, req_rdata_d;
    logic                 grant;

    // State and registered memory/response fields; reset drops an in-flight beat at once
    always_ff @(posedge clk_i or negedge rst_if.rst_n) begin
        if (!rst_if.rst_n) begin
            state_q         <= S_IDLE;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            mem_valid_q     <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            req_fulfilled_q <= '0;
            req_rdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            mem_valid_q     <= mem_valid_d;
            mem_write_q     <= mem_write_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            req_fulfilled_q <= req_fulfilled_d;
            req_rdata_q     <= req_rdata_d;
        end
    end

    // Arbitration, beat issue and response sequencing
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        mem_valid_d     = mem_valid_q;
        mem_write_d     = mem_write_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        req_fulfilled_d = '0;
        req_rdata_d     = req_rdata_q;
        grant           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i != '0) begin
                    // on a tie the requester that did not own the last burst wins
                    if (req_valid_i[0] && req_valid_i[1]) begin
                        grant = ~last_owner_q;
                    end else begin
                        grant = req_valid_i[1];
                    end
                    owner_d     = grant;
                    mem_valid_d = 1'b1;
                    mem_write_d = req_write_i[grant];
                    mem_addr_d  = req_addr_i[grant];
                    mem_wdata_d = req_wdata_i[grant];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_fulfilled_i) begin
                    if (!mem_write_q) begin
                        req_rdata_d = mem_rdata_i;
                    end
                    mem_valid_d              = 1'b0;
                    req_fulfilled_d[owner_q] = 1'b1;
                    state_d                  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                // a locked owner chains its next beat without re-arbitration
                if (req_lock_i[owner_q] && req_valid_i[owner_q]) begin
                    mem_valid_d = 1'b1;
                    mem_write_d = req_write_i[owner_q];
                    mem_addr_d  = req_addr_i[owner_q];
                    mem_wdata_d = req_wdata_i[owner_q];
                    state_d     = S_ISSUE;
                end else begin
                    last_owner_d = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_fulfilled_o = req_fulfilled_q;
    assign req_rdata_o     = req_rdata_q;
    assign mem_valid_o     = mem_valid_q;
    assign mem_write_o     = mem_write_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;

`ifdef HMEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] stat_grants_q;
    logic [NUM_REQ-1:0][31:0] stat_wait_q;

    // Saturating per-requester grant and contention counters
    always_ff @(posedge clk_i or negedge rst_if.rst_n) begin
        if (!rst_if.rst_n) begin
            stat_grants_q <= '0;
            stat_wait_q   <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (state_q == S_IDLE && state_d == S_ISSUE && owner_d == 1'(r)
                    && stat_grants_q[r] != 32'hFFFF_FFFF) begin
                    stat_grants_q[r] <= stat_grants_q[r] + 32'd1;
                end
                if (req_valid_i[r] && state_q != S_IDLE && owner_q != 1'(r)
                    && stat_wait_q[r] != 32'hFFFF_FFFF) begin
                    stat_wait_q[r] <= stat_wait_q[r] + 32'd1;
                end
            end
        end
    end

    assign stat_grants_o      = stat_grants_q;
    assign stat_wait_cycles_o = stat_wait_q;
`endif

endmodule

// File: tb/tb_hmem_arbiter.sv
// tb/tb_hmem_arbiter.sv - self-checking bench for hmem_arbiter: directed cases plus randomized agents vs. transaction model
module tb_hmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    reset_if rst_bus();

    logic [1:0]        req_valid, req_lock, req_write;
    logic [1:0][31:0]  req_addr, req_wdata;
    logic [1:0]        req_fulfilled;
    logic [31:0]       req_rdata;
    logic              mem_valid, mem_write;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic              mem_fulfilled;
`ifdef HMEM_ARB_STATS_EN
    logic [1:0][31:0]  stat_grants, stat_wait_cycles;
`endif

    hmem_arbiter #(.XLEN(32), .NUM_REQ(2)) dut (
        .clk_i           (clk),
        .rst_if          (rst_bus),
        .req_valid_i     (req_valid),
        .req_lock_i      (req_lock),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_fulfilled_o (req_fulfilled),
        .req_rdata_o     (req_rdata),
        .mem_valid_o     (mem_valid),
        .mem_write_o     (mem_write),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata),
        .mem_fulfilled_i (mem_fulfilled)
`ifdef HMEM_ARB_STATS_EN
        ,
        .stat_grants_o      (stat_grants),
        .stat_wait_cycles_o (stat_wait_cycles)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        req_lock      = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_fulfilled = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic set_beat(input int r, input logic v, input logic lk, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        req_valid[r] = v;
        req_lock[r]  = lk;
        req_write[r] = wr;
        req_addr[r]  = a;
        req_wdata[r] = d;
    endtask

    // Advance negedges until a beat is presented; the count is the observed latency
    task automatic wait_mem(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!mem_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n, exp_cycles);
    endtask

    // Memory acknowledges after lat cycles; returns at the negedge of the response cycle
    task automatic serve(input int lat, input logic [31:0] rd);
        repeat (lat - 1) @(negedge clk);
        mem_fulfilled = 1'b1;
        mem_rdata     = rd;
        @(negedge clk);
        mem_fulfilled = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_bus.rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_bus.rst_n = 1'b1;
    endtask

    // Randomized requester agents: bursts of 1..8 beats, continuation beats carry lock
    int          a_len [2];
    int          a_beat[2];
    int          a_gap [2];
    logic        a_wr  [2];
    logic [31:0] a_base[2];
    logic [31:0] a_data[2];

    task automatic new_burst(input int r);
        a_len[r]  = int'($urandom_range(1, 8));
        a_beat[r] = 0;
        a_wr[r]   = 1'($urandom_range(0, 1));
        a_base[r] = (r == 0 ? 32'h1000_0000 : 32'h8000_0000) | ($urandom_range(0, 4095) << 5);
        a_data[r] = $urandom;
        a_gap[r]  = int'($urandom_range(0, 3));
    endtask

    task automatic drive_agents();
        for (int r = 0; r < 2; r++) begin
            req_valid[r] = (a_gap[r] == 0);
            req_lock[r]  = (a_beat[r] != 0);
            req_write[r] = a_wr[r];
            req_addr[r]  = a_base[r] + 32'(a_beat[r] * 4);
            req_wdata[r] = a_data[r] + 32'(a_beat[r]);
        end
    endtask

    // Transaction-level reference: who owns the port, what the last read returned
    logic        m_owner, m_last, m_wr, m_busy, m_pulse, m_chain, m_spur, start_next;
    logic [31:0] m_rdata;
    int          m_lat, progress;
    bit          stuck;

    task automatic rand_step();
        logic [1:0] v_s;
        int         done_idx;
        bit         new_beat;
        v_s      = req_valid;
        done_idx = -1;
        progress++;
        if (m_spur) begin
            mem_fulfilled = 1'b0;
            m_spur        = 1'b0;
        end
        if (m_pulse) begin
            mem_fulfilled = 1'b0;
            m_pulse       = 1'b0;
            m_busy        = 1'b0;
            check_eq("rnd_fulfilled", req_fulfilled, m_owner ? 32'd2 : 32'd1);
            check_eq("rnd_rdata", req_rdata, m_rdata);
            check_eq("rnd_mem_valid_drop", mem_valid, 0);
            done_idx = int'(m_owner);
            progress = 0;
        end else begin
            check_eq("rnd_no_pulse", req_fulfilled, 0);
        end
        new_beat = mem_valid && !m_busy;
        check_eq("rnd_beat_start", new_beat, start_next);
        if (new_beat) begin
            if (!m_chain) begin
                m_owner = (v_s == 2'b11) ? ~m_last : v_s[1];
            end
            check_eq("rnd_addr", mem_addr, req_addr[m_owner]);
            check_eq("rnd_write", mem_write, req_write[m_owner]);
            check_eq("rnd_wdata", mem_wdata, req_wdata[m_owner]);
            m_wr   = req_write[m_owner];
            m_busy = 1'b1;
            m_lat  = int'($urandom_range(0, 3));
        end
        if (m_busy && !m_pulse) begin
            if (m_lat == 0) begin
                mem_fulfilled = 1'b1;
                mem_rdata     = $urandom;
                m_pulse       = 1'b1;
                if (!m_wr) m_rdata = mem_rdata;
            end else begin
                m_lat--;
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (done_idx == r) begin
                a_beat[r]++;
                if (a_beat[r] == a_len[r]) new_burst(r);
            end else if (a_gap[r] > 0) begin
                a_gap[r]--;
            end
        end
        drive_agents();
        if (done_idx >= 0) begin
            m_chain = req_valid[m_owner] && req_lock[m_owner];
            if (!m_chain) m_last = m_owner;
            start_next = m_chain;
        end else begin
            m_chain    = 1'b0;
            start_next = !m_busy && (req_valid != 2'b00);
        end
        if (!m_busy && $urandom_range(0, 3) == 0) begin
            mem_fulfilled = 1'b1;
            m_spur        = 1'b1;
        end
        if (progress > 100) begin
            check_eq("rnd_watchdog", progress, 0);
            stuck = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1);
    end

    initial begin
        rst_bus.rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_eq("rst_mem_valid", mem_valid, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_fulfilled", req_fulfilled, 0);
        check_eq("rst_rdata", req_rdata, 0);
        rst_bus.rst_n = 1'b1;
        @(negedge clk);

        // single dcache read
        set_beat(1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        wait_mem("t1_latency", 1);
        check_eq("t1_addr", mem_addr, 32'h100);
        check_eq("t1_write", mem_write, 0);
        serve(3, 32'hDEAD_BEEF);
        check_eq("t1_fulfilled", req_fulfilled, 2'b10);
        check_eq("t1_rdata", req_rdata, 32'hDEAD_BEEF);
        check_eq("t1_valid_drop", mem_valid, 0);
        req_valid = '0;
        @(negedge clk);
        check_eq("t1_pulse_len", req_fulfilled, 0);
        mem_fulfilled = 1'b1;
        mem_rdata     = 32'h1111_1111;
        @(negedge clk);
        mem_fulfilled = 1'b0;
        check_eq("t1_idle_ack_valid", mem_valid, 0);
        check_eq("t1_idle_ack_fulfilled", req_fulfilled, 0);
        check_eq("t1_idle_ack_rdata", req_rdata, 32'hDEAD_BEEF);

        // tie from reset, then round-robin hands over
        pulse_reset();
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        set_beat(1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
        wait_mem("t2_latency", 1);
        check_eq("t2_first_addr", mem_addr, 32'h40);
        serve(1, 32'h0000_4040);
        check_eq("t2_first_fulfilled", req_fulfilled, 2'b01);
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        wait_mem("t2_rearb_latency", 2);
        check_eq("t2_second_addr", mem_addr, 32'h80);
        serve(1, 32'h0000_8080);
        check_eq("t2_second_fulfilled", req_fulfilled, 2'b10);
        check_eq("t2_second_rdata", req_rdata, 32'h0000_8080);
        req_valid[1] = 1'b0;
        wait_mem("t2_third_latency", 2);
        check_eq("t2_third_addr", mem_addr, 32'h44);
        serve(1, 32'h0);
        check_eq("t2_third_fulfilled", req_fulfilled, 2'b01);
        req_valid = '0;
        @(negedge clk);

        // locked 8-beat dcache fill with icache waiting throughout
        set_beat(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        wait_mem("t3_first_latency", 1);
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check_eq("t3_beat_addr", mem_addr, 32'h200 + 32'(4 * i));
            serve(int'($urandom_range(1, 3)), 32'h3000 + 32'(i));
            check_eq("t3_beat_fulfilled", req_fulfilled, 2'b10);
            check_eq("t3_beat_rdata", req_rdata, 32'h3000 + 32'(i));
            if (i < 7) begin
                set_beat(1, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * (i + 1)), 32'h0);
                wait_mem("t3_locked_latency", 1);
            end else begin
                set_beat(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        wait_mem("t3_icache_latency", 2);
        check_eq("t3_icache_addr", mem_addr, 32'h500);
        serve(2, 32'h0000_5555);
        check_eq("t3_icache_fulfilled", req_fulfilled, 2'b01);
        check_eq("t3_icache_rdata", req_rdata, 32'h0000_5555);
        req_valid = '0;
        @(negedge clk);

        // writeback then fill
        set_beat(1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h1234_5678);
        wait_mem("t4_wb_latency", 1);
        check_eq("t4_wb_write", mem_write, 1);
        check_eq("t4_wb_addr", mem_addr, 32'h300);
        check_eq("t4_wb_wdata", mem_wdata, 32'h1234_5678);
        serve(2, 32'hAAAA_5555);
        check_eq("t4_wb_fulfilled", req_fulfilled, 2'b10);
        check_eq("t4_wb_rdata_kept", req_rdata, 32'h0000_5555);
        set_beat(1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0);
        wait_mem("t4_fill_latency", 2);
        check_eq("t4_fill_write", mem_write, 0);
        check_eq("t4_fill_addr", mem_addr, 32'h304);
        serve(1, 32'hCAFE_F00D);
        check_eq("t4_fill_rdata", req_rdata, 32'hCAFE_F00D);
        req_valid = '0;
        @(negedge clk);

        // asynchronous reset in ISSUE and in RESPOND
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0);
        wait_mem("t5_latency", 1);
        #2 rst_bus.rst_n = 1'b0;
        #1;
        check_eq("t5_async_mem_valid", mem_valid, 0);
        check_eq("t5_async_fulfilled", req_fulfilled, 0);
        check_eq("t5_async_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_bus.rst_n = 1'b1;
        wait_mem("t5_restart_latency", 1);
        check_eq("t5_restart_addr", mem_addr, 32'h600);
        serve(1, 32'h0000_6666);
        check_eq("t5_restart_fulfilled", req_fulfilled, 2'b01);
        check_eq("t5_restart_rdata", req_rdata, 32'h0000_6666);
        #2 rst_bus.rst_n = 1'b0;
        #1;
        check_eq("t5_resp_async_fulfilled", req_fulfilled, 0);
        check_eq("t5_resp_async_rdata", req_rdata, 0);
        idle_inputs();
        @(negedge clk);
        rst_bus.rst_n = 1'b1;

`ifdef HMEM_ARB_STATS_EN
        // icache stalls behind a 4-cycle dcache beat plus its response cycle
        pulse_reset();
        set_beat(1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h0);
        wait_mem("st_dcache_latency", 1);
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'h780, 32'h0);
        serve(4, 32'h0);
        req_valid[1] = 1'b0;
        wait_mem("st_icache_latency", 2);
        check_eq("st_icache_addr", mem_addr, 32'h780);
        check_eq("st_wait0", stat_wait_cycles[0], 5);
        check_eq("st_wait1", stat_wait_cycles[1], 0);
        check_eq("st_grants1", stat_grants[1], 1);
        check_eq("st_grants0", stat_grants[0], 1);
        serve(1, 32'h0);
        req_valid = '0;
        @(negedge clk);
`endif

        // randomized traffic against the transaction model
        @(negedge clk);
        rst_bus.rst_n = 1'b0;
        idle_inputs();
        new_burst(0);
        new_burst(1);
        drive_agents();
        m_owner = 1'b0; m_last = 1'b1; m_wr = 1'b0; m_busy = 1'b0; m_pulse = 1'b0;
        m_chain = 1'b0; m_spur = 1'b0; m_rdata = '0; m_lat = 0; progress = 0; stuck = 1'b0;
        start_next = (req_valid != 2'b00);
        @(negedge clk);
        rst_bus.rst_n = 1'b1;
        for (int s = 0; s < 3000 && !stuck; s++) begin
            @(negedge clk);
            rand_step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
